// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared widths, FSM state type and one-hot helper for the pulse decoder
package dec_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } dec_state_t;

    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_code_fifo.sv
// rtl/dec_code_fifo.sv - code buffer: circular FIFO with DEC_FIFO_EN, single register otherwise
module dec_code_fifo
    import dec_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [CODE_W-1:0] push_code_i,
    input  logic              pop_i,
    output logic [CODE_W-1:0] pop_code_o,
    output logic              full_o,
    output logic              empty_o
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dec_code_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

`ifdef DEC_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_code_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_code_i;
        end
    end

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [CODE_W-1:0] code_q;
    logic              valid_q;

    assign full_o     = valid_q;
    assign empty_o    = ~valid_q;
    assign pop_code_o = code_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else if (push_i && !valid_q) begin
            code_q  <= push_code_i;
            valid_q <= 1'b1;
        end else if (pop_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - buffered 3-to-8 one-hot pulse generator; DEC_FIFO_EN selects a FIFO buffer
module onehot_pulse_decoder
    import dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              en,
    output logic [OUT_W-1:0]  y,
    output logic              done,
    output logic              busy
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("onehot_pulse_decoder: HOLD_CYCLES must be in 1..255");
    end

    localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    dec_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  y_q;
    logic              done_q;
    logic [CODE_W-1:0] fifo_code;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign in_ready = ~fifo_full & ~rst;
    assign push     = in_valid & in_ready;
    assign pop      = en & ~fifo_empty & ((state_q == IDLE) || (state_q == GAP));

    dec_code_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_code_i (in_code),
        .pop_i       (pop),
        .pop_code_o  (fifo_code),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // While en is low the ACTIVE state holds both its counter and its line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    y_q    <= '0;
                    if (pop) begin
                        y_q     <= onehot(fifo_code);
                        cnt_q   <= CNT_LOAD;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (en) begin
                        if (cnt_q == '0) begin
                            y_q     <= '0;
                            done_q  <= 1'b1;
                            state_q <= GAP;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                GAP: begin
                    done_q <= 1'b0;
                    if (pop) begin
                        y_q     <= onehot(fifo_code);
                        cnt_q   <= CNT_LOAD;
                        state_q <= ACTIVE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    y_q     <= '0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign y    = en ? y_q : '0;
    assign done = done_q;
    assign busy = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - directed self-checking bench for onehot_pulse_decoder (DEC_FIFO_EN aware)
module tb_onehot_pulse_decoder;

    logic       clk;
    logic       rst;
    logic [2:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic       en;
    logic [7:0] y;
    logic       done;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DEC_FIFO_EN
    localparam int NFULL = 4;
`else
    localparam int NFULL = 1;
`endif

    onehot_pulse_decoder #(
        .HOLD_CYCLES (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_code  (in_code),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .en       (en),
        .y        (y),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] line_of(input logic [2:0] code);
        logic [7:0] one;
        one = 8'h01;
        return one << code;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_code = 3'd3; en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h expected 00", y); end
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        en = 1'b1; in_code = 3'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (y !== 8'h00) begin n_fail++; $display("FAIL single_no_bypass: got %h expected 00", y); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (y !== 8'h20) begin n_fail++; $display("FAIL single_y cyc %0d: got %h expected 20", c, y); end
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_early cyc %0d: got %b expected 0", c, done); end
        end
        tick();
        n_checks++;
        if (y !== 8'h00) begin n_fail++; $display("FAIL single_gap_y: got %h expected 00", y); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL single_gap_done: got %b expected 1", done); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b expected 0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [3];
        int         idx;
        logic       acc;
        logic [7:0] exp_y;
        logic       exp_done;
        int         p;
        int         r;
        codes[0] = 3'd0; codes[1] = 3'd7; codes[2] = 3'd3;
        en = 1'b1; idx = 0; in_valid = 1'b1; in_code = codes[0];
        for (int c = 0; c < 20; c++) begin
            acc = in_valid & in_ready;
            tick();
            if (acc) idx++;
            in_valid = (idx < 3);
            if (idx < 3) in_code = codes[idx];
            p = (c - 1) / 5;
            r = (c - 1) % 5;
            exp_y    = (c >= 1 && p < 3 && r < 4) ? line_of(codes[(p < 3) ? p : 0]) : 8'h00;
            exp_done = (c >= 1 && p < 3 && r == 4);
            n_checks++;
            if (y !== exp_y) begin n_fail++; $display("FAIL b2b_y cyc %0d: got %h expected %h", c, y, exp_y); end
            n_checks++;
            if (done !== exp_done) begin n_fail++; $display("FAIL b2b_done cyc %0d: got %b expected %b", c, done, exp_done); end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full();
        logic [2:0] fc [4];
        logic [7:0] exp_y;
        int         p;
        int         r;
        fc[0] = 3'd6; fc[1] = 3'd1; fc[2] = 3'd4; fc[3] = 3'd2;
        en = 1'b0;
        for (int i = 0; i < NFULL; i++) begin
            in_code = fc[i]; in_valid = 1'b1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_ready %0d: got %b expected 1", i, in_ready); end
            tick();
        end
        in_code = 3'd7;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready cyc %0d: got %b expected 0", c, in_ready); end
            n_checks++;
            if (y !== 8'h00) begin n_fail++; $display("FAIL full_paused_y cyc %0d: got %h expected 00", c, y); end
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", busy); end
        en = 1'b1;
        for (int c = 0; c < NFULL * 5 + 2; c++) begin
            tick();
            p = c / 5;
            r = c % 5;
            exp_y = (p < NFULL && r < 4) ? line_of(fc[(p < NFULL) ? p : 0]) : 8'h00;
            n_checks++;
            if (y !== exp_y) begin n_fail++; $display("FAIL full_drain_y cyc %0d: got %h expected %h", c, y, exp_y); end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_end_busy: got %b expected 0", busy); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_end_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_enable_pause();
        logic       en_seq   [8];
        logic [7:0] y_exp    [8];
        logic       done_exp [8];
        int         high;
        en_seq   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        y_exp    = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 8'h04, 8'h00};
        done_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        high = 0;
        en = 1'b1; in_code = 3'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            en = en_seq[c];
            #1;
            if (y == 8'h04) high++;
            n_checks++;
            if (y !== y_exp[c]) begin n_fail++; $display("FAIL pause_y cyc %0d: got %h expected %h", c, y, y_exp[c]); end
            n_checks++;
            if (done !== done_exp[c]) begin n_fail++; $display("FAIL pause_done cyc %0d: got %b expected %b", c, done, done_exp[c]); end
        end
        n_checks++;
        if (high != 4) begin n_fail++; $display("FAIL pause_high_time: got %0d expected 4", high); end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL pause_end_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] codes [3];
        int         idx;
        logic       acc;
        codes[0] = 3'd1; codes[1] = 3'd2; codes[2] = 3'd4;
        en = 1'b1; idx = 0; in_valid = 1'b1; in_code = codes[0];
        for (int c = 0; c < 3; c++) begin
            acc = in_valid & in_ready;
            tick();
            if (acc) idx++;
            in_valid = (idx < 3);
            if (idx < 3) in_code = codes[idx];
        end
        n_checks++;
        if (y !== 8'h02) begin n_fail++; $display("FAIL mid_pulse_y: got %h expected 02", y); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_pulse_busy: got %b expected 1", busy); end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        n_checks++;
        if (y !== 8'h00) begin n_fail++; $display("FAIL mid_reset_y: got %h expected 00", y); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done: got %b expected 0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            n_checks++;
            if (y !== 8'h00 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet cyc %0d: got y=%h done=%b expected y=00 done=0", c, y, done);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; en = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_enable_pause();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
